// File: rtl/vdp_io_pkg.sv
// Shared types and defaults for the VDP I/O sequencer.
package vdp_io_pkg;

  localparam int VDP_FIFO_DEPTH_DEF  = 4;
  localparam int VDP_ACK_TIMEOUT_DEF = 255;
  localparam int VDP_WFIFO_W         = 10;

  // Sequencer FSM states; exported on state_o for observation.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WR_REQ = 2'd1,
    ST_RD_REQ = 2'd2
  } vdp_io_state_e;

  // A write-FIFO entry is {port, data}.
  function automatic logic [VDP_WFIFO_W-1:0] pack_wr(input logic [1:0] port,
                                                     input logic [7:0] data);
    return {port, data};
  endfunction

endpackage

// File: rtl/vdp_io_wfifo.sv
// Synchronous write FIFO for queued VDP OUT accesses.
// Full/empty derive from an occupancy count; a push while full is accepted
// only when a pop happens in the same cycle.
module vdp_io_wfifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk_w,
  input  logic         reset_n_w,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Storage needs no reset: empty/count gate every read of it.
  always_ff @(posedge clk_w) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; DEPTH is a power of 2 so pointers wrap naturally.
  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vdp_io_sequencer.sv
// CPU-to-VDP I/O sequencer: turns filtered CPU strobes into VDP accesses.
// Writes are queued in a small FIFO and always drain before a pending read.
//
// VDP handshake: vdp_req_o is raised with vdp_wrt_o/vdp_adr_o/vdp_dbo_o stable
// and held until vdp_ack_i is seen high for one cycle; the access completes on
// that ack cycle and vdp_req_o then drops for at least one cycle before the next
// access. If no ack arrives within ACK_TIMEOUT request cycles the access is
// abandoned and err_o[1] is set.
module vdp_io_sequencer
  import vdp_io_pkg::*;
#(
  parameter int FIFO_DEPTH  = VDP_FIFO_DEPTH_DEF,
  parameter int ACK_TIMEOUT = VDP_ACK_TIMEOUT_DEF
) (
  input  logic          clk_w,
  input  logic          reset_n_w,
  input  logic          csr_n_i,
  input  logic          csw_n_i,
  input  logic [1:0]    port_i,
  input  logic [7:0]    cd_i,
  output logic          vdp_req_o,
  output logic          vdp_wrt_o,
  output logic [1:0]    vdp_adr_o,
  output logic [7:0]    vdp_dbo_o,
  input  logic          vdp_ack_i,
  input  logic [7:0]    vdp_dbi_i,
  output logic [7:0]    rd_data_o,
  output logic          rd_valid_o,
  output logic          fifo_full_o,
  output logic [1:0]    err_o,
  output vdp_io_state_e state_o
);

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  // The counter is 0 in the first request cycle, so this value marks the
  // ACK_TIMEOUT-th cycle of waiting.
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  vdp_io_state_e state_q;
  vdp_io_state_e state_nxt;

  logic                   csr_q;
  logic                   csw_q;
  logic                   rd_fall;
  logic                   wr_fall;
  logic                   both_fall;
  logic                   rd_only;
  logic                   wr_only;

  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [VDP_WFIFO_W-1:0] fifo_head;
  logic                   overrun;

  logic                   rd_pend;
  logic [1:0]             rd_port;
  logic [1:0]             rd_adr_q;
  logic                   rd_done;
  logic                   tmo_hit;
  logic                   tmo_last;
  logic [TW-1:0]          tmo_cnt;

  // Falling-edge detection against the previous-cycle strobe level.
  assign rd_fall   = csr_q & ~csr_n_i;
  assign wr_fall   = csw_q & ~csw_n_i;
  assign both_fall = rd_fall & wr_fall;
  assign rd_only   = rd_fall & ~wr_fall;
  assign wr_only   = wr_fall & ~rd_fall;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign fifo_push = wr_only & (~fifo_full | fifo_pop);
  assign overrun   = wr_only & fifo_full & ~fifo_pop;

  assign tmo_last    = (tmo_cnt == TMO_LAST);
  assign fifo_full_o = fifo_full;
  assign state_o     = state_q;

  vdp_io_wfifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (VDP_WFIFO_W)
  ) u_wfifo (
    .clk_w     (clk_w),
    .reset_n_w (reset_n_w),
    .push      (fifo_push),
    .wdata     (pack_wr(port_i, cd_i)),
    .pop       (fifo_pop),
    .rdata     (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Strobe history; held at 1 in reset so a strobe low at release is not an edge.
  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      csr_q <= 1'b1;
      csw_q <= 1'b1;
    end else begin
      csr_q <= csr_n_i;
      csw_q <= csw_n_i;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) state_q <= ST_IDLE;
    else            state_q <= state_nxt;
  end

  // Next-state and VDP bus outputs; bus is quiet (all zero) whenever idle.
  always_comb begin
    state_nxt = state_q;
    vdp_req_o = 1'b0;
    vdp_wrt_o = 1'b0;
    vdp_adr_o = 2'd0;
    vdp_dbo_o = 8'd0;
    fifo_pop  = 1'b0;
    rd_done   = 1'b0;
    tmo_hit   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty)  state_nxt = ST_WR_REQ;
        else if (rd_pend) state_nxt = ST_RD_REQ;
      end
      ST_WR_REQ: begin
        vdp_req_o = 1'b1;
        vdp_wrt_o = 1'b1;
        vdp_adr_o = fifo_head[9:8];
        vdp_dbo_o = fifo_head[7:0];
        if (vdp_ack_i) begin
          fifo_pop  = 1'b1;
          state_nxt = ST_IDLE;
        end else if (tmo_last) begin
          fifo_pop  = 1'b1;
          tmo_hit   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_RD_REQ: begin
        vdp_req_o = 1'b1;
        vdp_adr_o = rd_adr_q;
        if (vdp_ack_i) begin
          rd_done   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (tmo_last) begin
          rd_done   = 1'b1;
          tmo_hit   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Ack timeout counter; cleared while idle so every access starts from zero.
  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w)              tmo_cnt <= '0;
    else if (state_q == ST_IDLE) tmo_cnt <= '0;
    else if (!tmo_last)          tmo_cnt <= tmo_cnt + TW'(1);
  end

  // Read bookkeeping: one outstanding read; a newer strobe only replaces the port.
  // The port driven on the bus is frozen on entry to RD_REQ so it cannot glitch.
  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      rd_pend    <= 1'b0;
      rd_port    <= 2'd0;
      rd_adr_q   <= 2'd0;
      rd_data_o  <= 8'hFF;
      rd_valid_o <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) && (state_nxt == ST_RD_REQ)) rd_adr_q <= rd_port;
      if (rd_done) begin
        rd_data_o  <= vdp_ack_i ? vdp_dbi_i : 8'hFF;
        rd_valid_o <= 1'b1;
        rd_pend    <= 1'b0;
      end
      if (rd_only) begin
        rd_pend    <= 1'b1;
        rd_port    <= port_i;
        rd_valid_o <= 1'b0;
      end
    end
  end

  // Sticky error flags: [0] dropped/ambiguous write, [1] ack timeout.
  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      err_o <= 2'b00;
    end else begin
      if (overrun | both_fall) err_o[0] <= 1'b1;
      if (tmo_hit)             err_o[1] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vdp_io_sequencer.sv
// Self-checking bench for vdp_io_sequencer: directed scenarios plus a
// randomized run checked against an access-order model.
module tb_vdp_io_sequencer;
  import vdp_io_pkg::*;

  localparam int ACK_TIMEOUT = 255;
  localparam int FIFO_DEPTH  = 4;

  logic          clk_w;
  logic          reset_n_w;
  logic          csr_n_i;
  logic          csw_n_i;
  logic [1:0]    port_i;
  logic [7:0]    cd_i;
  logic          vdp_req_o;
  logic          vdp_wrt_o;
  logic [1:0]    vdp_adr_o;
  logic [7:0]    vdp_dbo_o;
  logic          vdp_ack_i;
  logic [7:0]    vdp_dbi_i;
  logic [7:0]    rd_data_o;
  logic          rd_valid_o;
  logic          fifo_full_o;
  logic [1:0]    err_o;
  vdp_io_state_e state_o;

  int n_cmp;
  int n_fail;

  // VDP model controls and observations
  bit         ack_en;
  int         ack_lat;
  bit         use_fixed;
  logic [7:0] fixed_dbi;
  int         gap_err;
  int         req_cycles;
  logic [10:0] acc_log[$];   // {wrt, adr, dbo (0 for reads)}
  logic [7:0]  rd_dbi_q[$];  // data handed back on each acked read
  logic [10:0] exp_q[$];     // expected access order

  vdp_io_sequencer #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk_w       (clk_w),
    .reset_n_w   (reset_n_w),
    .csr_n_i     (csr_n_i),
    .csw_n_i     (csw_n_i),
    .port_i      (port_i),
    .cd_i        (cd_i),
    .vdp_req_o   (vdp_req_o),
    .vdp_wrt_o   (vdp_wrt_o),
    .vdp_adr_o   (vdp_adr_o),
    .vdp_dbo_o   (vdp_dbo_o),
    .vdp_ack_i   (vdp_ack_i),
    .vdp_dbi_i   (vdp_dbi_i),
    .rd_data_o   (rd_data_o),
    .rd_valid_o  (rd_valid_o),
    .fifo_full_o (fifo_full_o),
    .err_o       (err_o),
    .state_o     (state_o)
  );

  // clock
  initial begin
    clk_w = 1'b0;
    forever #5 clk_w = ~clk_w;
  end

  // VDP responder: acks after ack_lat extra request cycles, logs each access
  initial begin : responder
    int wait_cnt;
    logic [7:0] dbi;
    wait_cnt  = 0;
    vdp_ack_i = 1'b0;
    vdp_dbi_i = 8'h00;
    forever begin
      @(negedge clk_w);
      if (!reset_n_w) begin
        vdp_ack_i = 1'b0;
        wait_cnt  = 0;
      end else if (vdp_ack_i) begin
        vdp_ack_i = 1'b0;
        wait_cnt  = 0;
        if (vdp_req_o) gap_err++;
      end else if (vdp_req_o) begin
        req_cycles++;
        if (ack_en && wait_cnt >= ack_lat) begin
          dbi       = use_fixed ? fixed_dbi : 8'($urandom);
          vdp_ack_i = 1'b1;
          vdp_dbi_i = dbi;
          if (!vdp_wrt_o) rd_dbi_q.push_back(dbi);
          acc_log.push_back({vdp_wrt_o, vdp_adr_o, vdp_wrt_o ? vdp_dbo_o : 8'h00});
        end
        wait_cnt++;
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk_w);
    reset_n_w = 1'b0;
    csr_n_i   = 1'b1;
    csw_n_i   = 1'b1;
    repeat (2) @(negedge clk_w);
    reset_n_w = 1'b1;
    acc_log.delete();
    rd_dbi_q.delete();
    exp_q.delete();
    gap_err    = 0;
    req_cycles = 0;
  endtask

  task automatic do_out(input logic [1:0] p, input logic [7:0] d);
    @(negedge clk_w);
    port_i  = p;
    cd_i    = d;
    csw_n_i = 1'b0;
    @(negedge clk_w);
    csw_n_i = 1'b1;
  endtask

  task automatic do_in(input logic [1:0] p);
    @(negedge clk_w);
    port_i  = p;
    csr_n_i = 1'b0;
    @(negedge clk_w);
    csr_n_i = 1'b1;
  endtask

  task automatic wait_log(input int n, input int budget);
    int c;
    c = 0;
    while (acc_log.size() < n && c < budget) begin
      @(negedge clk_w);
      c++;
    end
    if (acc_log.size() < n) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_log: got %0d accesses, required %0d", acc_log.size(), n);
    end
  endtask

  task automatic wait_rd_valid(input int budget, output int cyc);
    cyc = 0;
    while (!rd_valid_o && cyc < budget) begin
      @(negedge clk_w);
      cyc++;
    end
    if (!rd_valid_o) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_rd_valid: rd_valid_o still 0 after %0d cycles", budget);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    n_cmp++; if (vdp_req_o !== 1'b0)   begin n_fail++; $display("FAIL reset_req: got %b, required 0", vdp_req_o); end
    n_cmp++; if (vdp_wrt_o !== 1'b0)   begin n_fail++; $display("FAIL reset_wrt: got %b, required 0", vdp_wrt_o); end
    n_cmp++; if (vdp_adr_o !== 2'd0)   begin n_fail++; $display("FAIL reset_adr: got %h, required 0", vdp_adr_o); end
    n_cmp++; if (vdp_dbo_o !== 8'd0)   begin n_fail++; $display("FAIL reset_dbo: got %h, required 00", vdp_dbo_o); end
    n_cmp++; if (rd_data_o !== 8'hFF)  begin n_fail++; $display("FAIL reset_rd_data: got %h, required ff", rd_data_o); end
    n_cmp++; if (rd_valid_o !== 1'b0)  begin n_fail++; $display("FAIL reset_rd_valid: got %b, required 0", rd_valid_o); end
    n_cmp++; if (fifo_full_o !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b, required 0", fifo_full_o); end
    n_cmp++; if (err_o !== 2'b00)      begin n_fail++; $display("FAIL reset_err: got %b, required 00", err_o); end
    n_cmp++; if (state_o !== ST_IDLE)  begin n_fail++; $display("FAIL reset_state: got %0d, required %0d", state_o, ST_IDLE); end
  endtask

  task automatic test_single_out();
    apply_reset();
    ack_en = 1; ack_lat = 3; use_fixed = 0;
    do_out(2'd1, 8'h87);
    wait_log(1, 50);
    repeat (10) @(negedge clk_w);
    n_cmp++; if (acc_log.size() != 1) begin n_fail++; $display("FAIL single_count: got %0d accesses, required 1", acc_log.size()); end
    if (acc_log.size() > 0) begin
      n_cmp++; if (acc_log[0] !== {1'b1, 2'd1, 8'h87}) begin n_fail++; $display("FAIL single_access: got %h, required %h", acc_log[0], {1'b1, 2'd1, 8'h87}); end
    end
    n_cmp++; if (fifo_full_o !== 1'b0) begin n_fail++; $display("FAIL single_full: got %b, required 0", fifo_full_o); end
    n_cmp++; if (err_o !== 2'b00)      begin n_fail++; $display("FAIL single_err: got %b, required 00", err_o); end
  endtask

  task automatic test_overrun();
    apply_reset();
    ack_en = 0; ack_lat = 0;
    for (int i = 1; i <= 5; i++) do_out(2'd0, 8'(i));
    n_cmp++; if (fifo_full_o !== 1'b1) begin n_fail++; $display("FAIL ovr_full: got %b, required 1", fifo_full_o); end
    n_cmp++; if (err_o !== 2'b01)      begin n_fail++; $display("FAIL ovr_err: got %b, required 01", err_o); end
    ack_en = 1;
    wait_log(4, 60);
    repeat (10) @(negedge clk_w);
    n_cmp++; if (acc_log.size() != 4) begin n_fail++; $display("FAIL ovr_count: got %0d accesses, required 4", acc_log.size()); end
    for (int i = 0; i < 4 && i < acc_log.size(); i++) begin
      n_cmp++;
      if (acc_log[i] !== {1'b1, 2'd0, 8'(i + 1)}) begin
        n_fail++; $display("FAIL ovr_order[%0d]: got %h, required %h", i, acc_log[i], {1'b1, 2'd0, 8'(i + 1)});
      end
    end
    n_cmp++; if (fifo_full_o !== 1'b0) begin n_fail++; $display("FAIL ovr_drained_full: got %b, required 0", fifo_full_o); end
  endtask

  task automatic test_wr_then_rd();
    int cyc;
    apply_reset();
    ack_en = 1; ack_lat = 2; use_fixed = 1; fixed_dbi = 8'h5A;
    do_out(2'd0, 8'h3C);
    do_in(2'd1);
    wait_rd_valid(100, cyc);
    n_cmp++; if (acc_log.size() != 2) begin n_fail++; $display("FAIL wr_rd_count: got %0d accesses, required 2", acc_log.size()); end
    if (acc_log.size() == 2) begin
      n_cmp++; if (acc_log[0] !== {1'b1, 2'd0, 8'h3C}) begin n_fail++; $display("FAIL wr_rd_first: got %h, required %h", acc_log[0], {1'b1, 2'd0, 8'h3C}); end
      n_cmp++; if (acc_log[1] !== {1'b0, 2'd1, 8'h00}) begin n_fail++; $display("FAIL wr_rd_second: got %h, required %h", acc_log[1], {1'b0, 2'd1, 8'h00}); end
    end
    n_cmp++; if (rd_data_o !== 8'h5A)  begin n_fail++; $display("FAIL wr_rd_data: got %h, required 5a", rd_data_o); end
    n_cmp++; if (rd_valid_o !== 1'b1)  begin n_fail++; $display("FAIL wr_rd_valid: got %b, required 1", rd_valid_o); end
    use_fixed = 0;
  endtask

  task automatic test_read_latency();
    int lat;
    int cyc;
    apply_reset();
    ack_en = 1;
    for (int it = 0; it < 4; it++) begin
      lat     = $urandom_range(0, 4);
      ack_lat = lat;
      @(negedge clk_w);
      port_i  = 2'($urandom);
      csr_n_i = 1'b0;
      @(negedge clk_w);
      csr_n_i = 1'b1;
      n_cmp++; if (rd_valid_o !== 1'b0) begin n_fail++; $display("FAIL lat_clear[%0d]: rd_valid got %b, required 0", it, rd_valid_o); end
      wait_rd_valid(50, cyc);
      n_cmp++; if (cyc != 2 + lat) begin n_fail++; $display("FAIL lat_cycles[%0d]: got %0d, required %0d", it, cyc, 2 + lat); end
      n_cmp++;
      if (rd_dbi_q.size() == 0 || rd_data_o !== rd_dbi_q[rd_dbi_q.size()-1]) begin
        n_fail++; $display("FAIL lat_data[%0d]: got %h, required last driven dbi", it, rd_data_o);
      end
      repeat (3) @(negedge clk_w);
    end
  endtask

  task automatic test_timeout_read();
    int cyc;
    apply_reset();
    ack_en = 0;
    do_in(2'd1);
    wait_rd_valid(400, cyc);
    @(negedge clk_w);
    n_cmp++; if (req_cycles != ACK_TIMEOUT) begin n_fail++; $display("FAIL tmo_req_cycles: got %0d, required %0d", req_cycles, ACK_TIMEOUT); end
    n_cmp++; if (err_o !== 2'b10)     begin n_fail++; $display("FAIL tmo_err: got %b, required 10", err_o); end
    n_cmp++; if (rd_data_o !== 8'hFF) begin n_fail++; $display("FAIL tmo_rd_data: got %h, required ff", rd_data_o); end
    n_cmp++; if (rd_valid_o !== 1'b1) begin n_fail++; $display("FAIL tmo_rd_valid: got %b, required 1", rd_valid_o); end
    n_cmp++; if (state_o !== ST_IDLE) begin n_fail++; $display("FAIL tmo_state: got %0d, required %0d", state_o, ST_IDLE); end
    ack_en = 1;
  endtask

  task automatic test_reset_mid_wr();
    int c;
    apply_reset();
    ack_en = 0;
    do_out(2'd2, 8'hC3);
    c = 0;
    while (state_o !== ST_WR_REQ && c < 10) begin @(negedge clk_w); c++; end
    n_cmp++; if (vdp_req_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre_req: got %b, required 1", vdp_req_o); end
    #2 reset_n_w = 1'b0;
    #1;
    n_cmp++; if (vdp_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_req: got %b, required 0", vdp_req_o); end
    n_cmp++; if (state_o !== ST_IDLE) begin n_fail++; $display("FAIL rst_mid_state: got %0d, required %0d", state_o, ST_IDLE); end
    @(negedge clk_w);
    reset_n_w = 1'b1;
    ack_en    = 1; ack_lat = 0;
    acc_log.delete();
    repeat (20) @(negedge clk_w);
    n_cmp++; if (acc_log.size() != 0) begin n_fail++; $display("FAIL rst_mid_access: got %0d accesses, required 0", acc_log.size()); end
    n_cmp++; if (err_o !== 2'b00)     begin n_fail++; $display("FAIL rst_mid_err: got %b, required 00", err_o); end
  endtask

  task automatic test_both_fall();
    apply_reset();
    ack_en = 1; ack_lat = 0;
    @(negedge clk_w);
    port_i = 2'd3; cd_i = 8'hA5;
    csr_n_i = 1'b0; csw_n_i = 1'b0;
    @(negedge clk_w);
    csr_n_i = 1'b1; csw_n_i = 1'b1;
    repeat (10) @(negedge clk_w);
    n_cmp++; if (acc_log.size() != 0)  begin n_fail++; $display("FAIL both_access: got %0d accesses, required 0", acc_log.size()); end
    n_cmp++; if (err_o !== 2'b01)      begin n_fail++; $display("FAIL both_err: got %b, required 01", err_o); end
    n_cmp++; if (rd_valid_o !== 1'b0)  begin n_fail++; $display("FAIL both_rd_valid: got %b, required 0", rd_valid_o); end
  endtask

  task automatic test_random();
    int k;
    int cyc;
    logic [1:0] p;
    logic [7:0] d;
    apply_reset();
    ack_en = 1; use_fixed = 0;
    for (int r = 0; r < 12; r++) begin
      k       = $urandom_range(0, 3);
      ack_lat = $urandom_range(0, 4);
      for (int j = 0; j < k; j++) begin
        p = 2'($urandom); d = 8'($urandom);
        exp_q.push_back({1'b1, p, d});
        do_out(p, d);
      end
      if ($urandom_range(0, 1) == 1) begin
        p = 2'($urandom);
        exp_q.push_back({1'b0, p, 8'h00});
        do_in(p);
        wait_rd_valid(100, cyc);
        n_cmp++;
        if (rd_dbi_q.size() == 0 || rd_data_o !== rd_dbi_q[rd_dbi_q.size()-1]) begin
          n_fail++; $display("FAIL rand_rd_data[%0d]: got %h, required last driven dbi", r, rd_data_o);
        end
      end
      wait_log(exp_q.size(), 100);
    end
    repeat (5) @(negedge clk_w);
    n_cmp++; if (acc_log.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d, required %0d", acc_log.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < acc_log.size(); i++) begin
      n_cmp++;
      if (acc_log[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_access[%0d]: got %h, required %h", i, acc_log[i], exp_q[i]); end
    end
    n_cmp++; if (err_o !== 2'b00) begin n_fail++; $display("FAIL rand_err: got %b, required 00", err_o); end
    n_cmp++; if (gap_err != 0)    begin n_fail++; $display("FAIL rand_req_gap: got %0d back-to-back reqs, required 0", gap_err); end
  endtask

  // main sequence
  initial begin
    n_cmp = 0; n_fail = 0;
    reset_n_w = 1'b0;
    csr_n_i = 1'b1; csw_n_i = 1'b1;
    port_i = 2'd0; cd_i = 8'd0;
    ack_en = 1; ack_lat = 0; use_fixed = 0; fixed_dbi = 8'h00;
    gap_err = 0; req_cycles = 0;
    test_reset();
    test_single_out();
    test_overrun();
    test_wr_then_rd();
    test_read_latency();
    test_timeout_read();
    test_reset_mid_wr();
    test_both_fall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
